spdif_frame_sequencer: RTL and testbench

SPDIF_FRAME_SEQUENCER -- requirements
Module: spdif_frame_sequencer

---
 rtl/spdif_pkg.sv | 32 +++
 rtl/spdif_subframe_builder.sv | 85 ++++++++
 rtl/spdif_frame_sequencer.sv | 148 ++++++++++++++
 tb/tb_spdif_frame_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// ============================================================================
// spdif_pkg
// Shared S/PDIF frame constants, slot map and preamble encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package spdif_pkg;

  localparam int FRAME_CLKS       = 128;
  localparam int FRAMES_PER_BLOCK = 192;
  localparam int AUDIO_BITS       = 24;
  localparam int CS_BITS          = 32;

  localparam logic [4:0] SLOT_PRE_LAST  = 5'd3;
  localparam logic [4:0] SLOT_AUD_FIRST = 5'd4;
  localparam logic [4:0] SLOT_AUD_LAST  = 5'd27;
  localparam logic [4:0] SLOT_V         = 5'd28;
  localparam logic [4:0] SLOT_U         = 5'd29;
  localparam logic [4:0] SLOT_C         = 5'd30;
  localparam logic [4:0] SLOT_P         = 5'd31;

  typedef enum logic [1:0] {
    PRE_NONE = 2'b00,
    PRE_B    = 2'b01,
    PRE_M    = 2'b10,
    PRE_W    = 2'b11
  } pre_type_e;

endpackage

`default_nettype wire

// File: rtl/spdif_subframe_builder.sv
// ============================================================================
// spdif_subframe_builder
// Slot multiplexer, preamble select and running even parity for one subframe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spdif_subframe_builder
  import spdif_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_i,
  input  logic [6:0]            cnt_i,
  input  logic                  first_frame_i,
  input  logic [AUDIO_BITS-1:0] sample_l_i,
  input  logic [AUDIO_BITS-1:0] sample_r_i,
  input  logic                  v_i,
  input  logic                  c_i,
  output logic                  slot_strobe_o,
  output logic                  slot_bit_o,
  output logic [1:0]            pre_type_o
);

  logic                  w_subframe;
  logic [4:0]            w_slot;
  logic [4:0]            w_aud_idx;
  logic [AUDIO_BITS-1:0] w_aud;
  logic                  slot_bit_d;
  pre_type_e             pre_type_d;
  logic                  par_d;

  logic                  slot_strobe_q;
  logic                  slot_bit_q;
  pre_type_e             pre_type_q;
  logic                  par_q;

  assign w_subframe = cnt_i[6];
  assign w_slot     = cnt_i[5:1];
  assign w_aud_idx  = w_slot - SLOT_AUD_FIRST;
  assign w_aud      = w_subframe ? sample_r_i : sample_l_i;

  always_comb begin
    slot_bit_d = 1'b0;
    pre_type_d = PRE_NONE;
    par_d      = par_q;
    if (w_slot <= SLOT_PRE_LAST) begin
      pre_type_d = w_subframe ? PRE_W : (first_frame_i ? PRE_B : PRE_M);
    end else if (w_slot <= SLOT_AUD_LAST) begin
      slot_bit_d = w_aud[w_aud_idx];
    end else begin
      unique case (w_slot)
        SLOT_V:  slot_bit_d = v_i;
        SLOT_U:  slot_bit_d = 1'b0;
        SLOT_C:  slot_bit_d = c_i;
        default: slot_bit_d = par_q;
      endcase
    end
    // Accumulate once per slot; slot 4 restarts the sum for the new subframe.
    if (!cnt_i[0] && (w_slot >= SLOT_AUD_FIRST) && (w_slot <= SLOT_C)) begin
      par_d = (w_slot == SLOT_AUD_FIRST) ? slot_bit_d : (par_q ^ slot_bit_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !run_i) begin
      slot_strobe_q <= 1'b0;
      slot_bit_q    <= 1'b0;
      pre_type_q    <= PRE_NONE;
      par_q         <= 1'b0;
    end else begin
      slot_strobe_q <= ~cnt_i[0];
      slot_bit_q    <= slot_bit_d;
      pre_type_q    <= pre_type_d;
      par_q         <= par_d;
    end
  end

  assign slot_strobe_o = slot_strobe_q;
  assign slot_bit_o    = slot_bit_q;
  assign pre_type_o    = pre_type_q;

endmodule

`default_nettype wire

// File: rtl/spdif_frame_sequencer.sv
// ============================================================================
// spdif_frame_sequencer
// Frame/block counters, run FSM and sample handshake feeding the slot builder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spdif_frame_sequencer
  import spdif_pkg::*;
(
  input  logic                  clk_6144mhz,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CS_BITS-1:0]    cs_config,
  input  logic [AUDIO_BITS-1:0] sample_l,
  input  logic [AUDIO_BITS-1:0] sample_r,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  slot_strobe,
  output logic                  slot_bit,
  output logic [1:0]            pre_type,
  output logic [7:0]            frame_idx,
  output logic                  block_start,
  output logic                  underrun,
  output logic                  busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [6:0] CNT_LAST   = 7'(FRAME_CLKS - 1);
  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_BLOCK - 1);
  localparam logic [7:0] CS_FRAMES  = 8'(CS_BITS);

  state_e                state_q, state_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [7:0]            frame_q, frame_d;
  logic                  ready_q, ready_d;
  logic                  bstart_q, bstart_d;
  logic                  underrun_q;
  logic [AUDIO_BITS-1:0] smp_l_q, smp_r_q;
  logic                  v_q;
  logic [CS_BITS-1:0]    cs_shadow_q;
  logic                  w_c_bit;

  // en is only consulted at the last half-cell, so a frame always completes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    ready_d  = 1'b0;
    bstart_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d  = ST_RUN;
          cnt_d    = 7'd0;
          frame_d  = 8'd0;
          ready_d  = 1'b1;
          bstart_d = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == CNT_LAST) begin
          if (en) begin
            ready_d = 1'b1;
            if (frame_q == FRAME_LAST) begin
              frame_d  = 8'd0;
              bstart_d = 1'b1;
            end else begin
              frame_d = frame_q + 8'd1;
            end
          end else begin
            state_d = ST_IDLE;
            frame_d = 8'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_c_bit = (frame_d < CS_FRAMES) ? cs_shadow_q[frame_d[4:0]] : 1'b0;

  always_ff @(posedge clk_6144mhz) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 7'd0;
      frame_q     <= 8'd0;
      ready_q     <= 1'b0;
      bstart_q    <= 1'b0;
      underrun_q  <= 1'b0;
      smp_l_q     <= '0;
      smp_r_q     <= '0;
      v_q         <= 1'b0;
      cs_shadow_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      ready_q    <= ready_d;
      bstart_q   <= bstart_d;
      underrun_q <= ready_q & ~sample_valid;
      // A missed handshake substitutes silence flagged as invalid.
      if (ready_q) begin
        if (sample_valid) begin
          smp_l_q <= sample_l;
          smp_r_q <= sample_r;
          v_q     <= 1'b0;
        end else begin
          smp_l_q <= '0;
          smp_r_q <= '0;
          v_q     <= 1'b1;
        end
      end
      if (bstart_d) begin
        cs_shadow_q <= cs_config;
      end
    end
  end

  spdif_subframe_builder u_builder (
    .clk           (clk_6144mhz),
    .rst           (rst),
    .run_i         (state_d == ST_RUN),
    .cnt_i         (cnt_d),
    .first_frame_i (frame_d == 8'd0),
    .sample_l_i    (smp_l_q),
    .sample_r_i    (smp_r_q),
    .v_i           (v_q),
    .c_i           (w_c_bit),
    .slot_strobe_o (slot_strobe),
    .slot_bit_o    (slot_bit),
    .pre_type_o    (pre_type)
  );

  assign sample_ready = ready_q;
  assign frame_idx    = frame_q;
  assign block_start  = bstart_q;
  assign underrun     = underrun_q;
  assign busy         = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_spdif_frame_sequencer.sv
// ============================================================================
// tb_spdif_frame_sequencer
// Directed self-checking bench for the S/PDIF frame sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spdif_frame_sequencer;

  logic        clk_6144mhz = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] cs_config;
  logic [23:0] sample_l;
  logic [23:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        slot_strobe;
  logic        slot_bit;
  logic [1:0]  pre_type;
  logic [7:0]  frame_idx;
  logic        block_start;
  logic        underrun;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int bs_seen = 0;

  logic       sb [128];
  logic       st [128];
  logic       ur [128];
  logic [1:0] pt [128];

  always #5 clk_6144mhz = ~clk_6144mhz;

  spdif_frame_sequencer dut (
    .clk_6144mhz  (clk_6144mhz),
    .rst          (rst),
    .en           (en),
    .cs_config    (cs_config),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .slot_strobe  (slot_strobe),
    .slot_bit     (slot_bit),
    .pre_type     (pre_type),
    .frame_idx    (frame_idx),
    .block_start  (block_start),
    .underrun     (underrun),
    .busy         (busy)
  );

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk_6144mhz);
      if (block_start) bs_seen++;
      k++;
    end while (!sample_ready && k < budget);
    if (!sample_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready: sample_ready=%b after %0d cycles, required 1", sample_ready, k);
    end
  endtask

  task automatic capture_frame(input bit restore_valid);
    for (int k = 0; k < 128; k++) begin
      sb[k] = slot_bit;
      st[k] = slot_strobe;
      pt[k] = pre_type;
      ur[k] = underrun;
      @(negedge clk_6144mhz);
      if (restore_valid && k == 0) sample_valid = 1'b1;
    end
  endtask

  function automatic logic [31:0] sub_word(input int base);
    logic [31:0] w;
    for (int s = 0; s < 32; s++) w[s] = sb[base + 2 * s];
    return w;
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a, input logic v, input logic c);
    logic [31:0] w;
    w       = '0;
    w[27:4] = a;
    w[28]   = v;
    w[30]   = c;
    w[31]   = ^w[30:4];
    return w;
  endfunction

  function automatic int count_ur();
    int n;
    n = 0;
    for (int k = 0; k < 128; k++) if (ur[k]) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cs_config = '0; sample_l = '0; sample_r = '0; sample_valid = 1'b0;
    repeat (3) @(negedge clk_6144mhz);
    n_cmp++;
    if ({busy, sample_ready, slot_strobe, slot_bit, block_start, underrun} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {busy, sample_ready, slot_strobe, slot_bit, block_start, underrun});
    end
    n_cmp++;
    if (pre_type !== 2'b00) begin n_bad++; $display("FAIL reset_pre: got %b required 00", pre_type); end
    n_cmp++;
    if (frame_idx !== 8'd0) begin n_bad++; $display("FAIL reset_frame: got %0d required 0", frame_idx); end
    rst = 1'b0;
    @(negedge clk_6144mhz);
  endtask

  task automatic test_first_frame();
    int nst;
    cs_config = 32'h0; sample_l = 24'h000001; sample_r = 24'h800000; sample_valid = 1'b1; en = 1'b1;
    wait_ready(4);
    n_cmp++;
    if ({block_start, frame_idx} !== {1'b1, 8'd0}) begin
      n_bad++;
      $display("FAIL first_start: block_start=%b frame_idx=%0d required 1/0", block_start, frame_idx);
    end
    capture_frame(1'b0);
    n_cmp++;
    if ({pt[0], pt[7], pt[8], pt[64], pt[71], pt[72]} !== {2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00}) begin
      n_bad++;
      $display("FAIL first_pre: got %b %b %b %b %b %b required 01 01 00 11 11 00",
               pt[0], pt[7], pt[8], pt[64], pt[71], pt[72]);
    end
    nst = 0;
    for (int k = 0; k < 128; k++) if (st[k] !== ((k % 2) == 0)) nst++;
    n_cmp++;
    if (nst != 0) begin n_bad++; $display("FAIL first_strobe: %0d wrong half-cells required 0", nst); end
    n_cmp++;
    if (sub_word(0) !== 32'h80000010) begin
      n_bad++; $display("FAIL first_left: got %h required 80000010", sub_word(0));
    end
    n_cmp++;
    if (sub_word(64) !== 32'h88000000) begin
      n_bad++; $display("FAIL first_right: got %h required 88000000", sub_word(64));
    end
    n_cmp++;
    if (count_ur() != 0) begin n_bad++; $display("FAIL first_underrun: got %0d pulses required 0", count_ur()); end
  endtask

  task automatic test_block();
    n_cmp++;
    if ({sample_ready, frame_idx, pre_type, block_start} !== {1'b1, 8'd1, 2'b10, 1'b0}) begin
      n_bad++;
      $display("FAIL frame1: ready=%b idx=%0d pre=%b bs=%b required 1/1/10/0",
               sample_ready, frame_idx, pre_type, block_start);
    end
    bs_seen = 0;
    repeat (191) wait_ready(130);
    n_cmp++;
    if (bs_seen != 1) begin n_bad++; $display("FAIL block_pulses: got %0d required 1", bs_seen); end
    n_cmp++;
    if ({block_start, frame_idx, pre_type} !== {1'b1, 8'd0, 2'b01}) begin
      n_bad++;
      $display("FAIL frame192: bs=%b idx=%0d pre=%b required 1/0/01", block_start, frame_idx, pre_type);
    end
  endtask

  task automatic test_cs();
    wait_ready(130);
    cs_config = 32'h0000_0004;
    wait_ready(130);
    capture_frame(1'b0);
    n_cmp++;
    if ({sub_word(0), sub_word(64)} !== {32'h80000010, 32'h88000000}) begin
      n_bad++;
      $display("FAIL cs_old: got %h %h required 80000010 88000000", sub_word(0), sub_word(64));
    end
    repeat (189) wait_ready(130);
    n_cmp++;
    if (frame_idx !== 8'd0) begin n_bad++; $display("FAIL cs_wrap: got %0d required 0", frame_idx); end
    repeat (2) wait_ready(130);
    capture_frame(1'b0);
    n_cmp++;
    if ({sub_word(0), sub_word(64)} !== {32'h40000010, 32'h48000000}) begin
      n_bad++;
      $display("FAIL cs_new: got %h %h required 40000010 48000000", sub_word(0), sub_word(64));
    end
  endtask

  task automatic test_underrun();
    sample_l = 24'h123456;
    sample_r = 24'h654321;
    wait_ready(130);
    n_cmp++;
    if (frame_idx !== 8'd4) begin n_bad++; $display("FAIL ur_frame: got %0d required 4", frame_idx); end
    sample_valid = 1'b0;
    capture_frame(1'b1);
    n_cmp++;
    if (count_ur() != 1 || ur[1] !== 1'b1) begin
      n_bad++; $display("FAIL ur_pulse: got %0d pulses (ur[1]=%b) required 1 at half-cell 1", count_ur(), ur[1]);
    end
    n_cmp++;
    if ({sub_word(0), sub_word(64)} !== {32'h90000000, 32'h90000000}) begin
      n_bad++;
      $display("FAIL ur_silence: got %h %h required 90000000 90000000", sub_word(0), sub_word(64));
    end
    capture_frame(1'b0);
    n_cmp++;
    if (count_ur() != 0 || pt[0] !== 2'b10) begin
      n_bad++; $display("FAIL ur_recover: pulses=%0d pre=%b required 0/10", count_ur(), pt[0]);
    end
    n_cmp++;
    if ({sub_word(0), sub_word(64)} !== {exp_word(24'h123456, 1'b0, 1'b0), exp_word(24'h654321, 1'b0, 1'b0)}) begin
      n_bad++;
      $display("FAIL ur_frame5: got %h %h required %h %h", sub_word(0), sub_word(64),
               exp_word(24'h123456, 1'b0, 1'b0), exp_word(24'h654321, 1'b0, 1'b0));
    end
  endtask

  task automatic test_stop();
    int nb;
    repeat (20) @(negedge clk_6144mhz);
    en = 1'b0;
    repeat (5) @(negedge clk_6144mhz);
    en = 1'b1;
    repeat (15) @(negedge clk_6144mhz);
    en = 1'b0;
    nb = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_6144mhz);
      if (!busy) break;
      nb++;
    end
    n_cmp++;
    if (nb != 87) begin n_bad++; $display("FAIL stop_tail: got %0d busy cycles required 87", nb); end
    n_cmp++;
    if ({slot_strobe, slot_bit, sample_ready, block_start, underrun, pre_type, frame_idx} !== 15'b0) begin
      n_bad++;
      $display("FAIL stop_idle: strobe=%b bit=%b ready=%b bs=%b ur=%b pre=%b idx=%0d required all 0",
               slot_strobe, slot_bit, sample_ready, block_start, underrun, pre_type, frame_idx);
    end
  endtask

  task automatic test_rst_abort();
    en = 1'b1;
    wait_ready(4);
    repeat (60) @(negedge clk_6144mhz);
    rst = 1'b1;
    @(negedge clk_6144mhz);
    n_cmp++;
    if ({busy, slot_strobe, slot_bit, sample_ready, pre_type, frame_idx} !== 14'b0) begin
      n_bad++;
      $display("FAIL rst_abort: busy=%b strobe=%b bit=%b ready=%b pre=%b idx=%0d required all 0",
               busy, slot_strobe, slot_bit, sample_ready, pre_type, frame_idx);
    end
    rst = 1'b0;
    wait_ready(4);
    n_cmp++;
    if ({pre_type, frame_idx, block_start} !== {2'b01, 8'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_restart: pre=%b idx=%0d bs=%b required 01/0/1", pre_type, frame_idx, block_start);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_block();
    test_cs();
    test_underrun();
    test_stop();
    test_rst_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
